seq_div: RTL and testbench

SEQ_DIV -- requirements
Module: seq_div

---
 rtl/seq_div_pkg.sv | 18 +
 rtl/seq_div_step.sv | 24 ++
 rtl/seq_div.sv | 126 ++++++++++++
 tb/tb_seq_div.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and constants for the seq_div restoring divider.
// Optional zero-divisor shortcut is enabled by defining SEQ_DIV_ZERO_DETECT_EN.
package seq_div_pkg;

  localparam int unsigned SEQ_DIV_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step counter width; WIDTH >= 2 keeps this at least one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits, and report the quotient bit.
module seq_div_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem,
  output logic             o_q_bit
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  assign w_shift = {i_rem, i_bit};
  assign w_ge    = w_shift >= (WIDTH+2)'(i_divisor);
  // The shifted remainder never needs its top bit once the subtract happens.
  assign w_diff  = w_shift[WIDTH:0] - {1'b0, i_divisor};
  assign o_rem   = w_ge ? w_diff : w_shift[WIDTH:0];
  assign o_q_bit = w_ge;

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Define SEQ_DIV_ZERO_DETECT_EN to short-circuit divide-by-zero straight to DONE.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  localparam int unsigned      CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;

  logic             w_accept;
  logic             w_last;
  logic             w_zero_acc;
  logic [WIDTH:0]   w_rem_nxt;
  logic             w_q_bit;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_state == RUN) && (r_cnt == LAST);

`ifdef SEQ_DIV_ZERO_DETECT_EN
  assign w_zero_acc = w_accept && (b == '0);
`else
  assign w_zero_acc = 1'b0;
`endif

  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[WIDTH-1]),
    .i_divisor (r_div),
    .o_rem     (w_rem_nxt),
    .o_q_bit   (w_q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_zero_acc ? DONE : RUN;
      RUN:     if (w_last)   w_next = DONE;
      DONE:    if (w_accept) w_next = w_zero_acc ? DONE : RUN;
               else          w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_dvd  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_q    <= '0;
      r_r    <= '0;
    end else begin
      r_busy <= (w_next == RUN);
      r_done <= w_last || w_zero_acc;
      if (w_accept) begin
        r_rem <= '0;
        r_dvd <= a;
        r_div <= b;
        r_cnt <= '0;
        if (w_zero_acc) begin
          r_q <= '1;
          r_r <= a;
        end
      end else if (r_state == RUN) begin
        r_rem <= w_rem_nxt;
        r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_q <= {r_dvd[WIDTH-2:0], w_q_bit};
          r_r <= w_rem_nxt[WIDTH-1:0];
        end
      end
    end
  end

`ifdef SEQ_DIV_ZERO_DETECT_EN
  logic r_div_zero;

  always_ff @(posedge clk) begin
    if (!rst_n)        r_div_zero <= 1'b0;
    else if (w_accept) r_div_zero <= w_zero_acc;
  end

  assign div_zero = r_div_zero;
`else
  assign div_zero = 1'b0;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign q    = r_q;
  assign r    = r_r;

endmodule

// File: tb/tb_seq_div.sv
// Directed and table-driven bench for seq_div at WIDTH=4, valid with or
// without SEQ_DIV_ZERO_DETECT_EN defined.
module tb_seq_div;

  localparam int unsigned W = 4;
`ifdef SEQ_DIV_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif
  localparam int NORMAL_LAT = W + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         div_zero;

  int n_checks = 0;
  int n_pass   = 0;

  seq_div #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until done rises (bounded); start is dropped after the first edge.
  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc     = 0;
    busy_ok = 1'b1;
    do begin
      tick();
      start = 1'b0;
      cyc++;
      if (!done && busy !== 1'b1) busy_ok = 1'b0;
    end while (!done && cyc < 20);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input int edz, input int elat, input string nm);
    int cyc;
    bit bok;
    start = 1'b1;
    a     = ta;
    b     = tb_;
    wait_done(cyc, bok);
    check($sformatf("%s a=%0d b=%0d latency", nm, ta, tb_), cyc, elat);
    check($sformatf("%s a=%0d b=%0d busy_run", nm, ta, tb_), int'(bok), 1);
    check($sformatf("%s a=%0d b=%0d busy_at_done", nm, ta, tb_), int'(busy), 0);
    check($sformatf("%s a=%0d b=%0d q", nm, ta, tb_), int'(q), int'(eq));
    check($sformatf("%s a=%0d b=%0d r", nm, ta, tb_), int'(r), int'(er));
    check($sformatf("%s a=%0d b=%0d div_zero", nm, ta, tb_), int'(div_zero), edz);
    tick();
    check($sformatf("%s a=%0d b=%0d done_pulse", nm, ta, tb_), int'(done), 0);
    check($sformatf("%s a=%0d b=%0d q_hold", nm, ta, tb_), int'(q), int'(eq));
  endtask

  initial begin
    vec_t tbl[10];
    int   cyc;
    bit   bok;
    int   n_done;

    tbl[0] = '{a: 4'd7,  b: 4'd2,  q: 4'd3,  r: 4'd1};
    tbl[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0};
    tbl[2] = '{a: 4'd5,  b: 4'd7,  q: 4'd0,  r: 4'd5};
    tbl[3] = '{a: 4'd9,  b: 4'd3,  q: 4'd3,  r: 4'd0};
    tbl[4] = '{a: 4'd12, b: 4'd5,  q: 4'd2,  r: 4'd2};
    tbl[5] = '{a: 4'd0,  b: 4'd3,  q: 4'd0,  r: 4'd0};
    tbl[6] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0};
    tbl[7] = '{a: 4'd14, b: 4'd4,  q: 4'd3,  r: 4'd2};
    tbl[8] = '{a: 4'd1,  b: 4'd15, q: 4'd0,  r: 4'd1};
    tbl[9] = '{a: 4'd6,  b: 4'd0,  q: 4'd15, r: 4'd6};

    // Reset with start held high: reset must win.
    rst_n = 1'b0;
    start = 1'b1;
    a     = 4'd3;
    b     = 4'd1;
    tick();
    tick();
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset q", int'(q), 0);
    check("reset r", int'(r), 0);
    check("reset div_zero", int'(div_zero), 0);

    // First edge with rst_n high accepts start.
    rst_n = 1'b1;
    run_op(4'd7, 4'd2, 4'd3, 4'd1, 0, NORMAL_LAT, "first");

    // Table of directed vectors.
    for (int i = 0; i < 10; i++) begin
      bit is_z;
      is_z = (tbl[i].b == '0);
      run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
             int'(is_z && ZD), (is_z && ZD) ? 1 : NORMAL_LAT, $sformatf("tbl%0d", i));
    end

    // Back-to-back: second start issued in the DONE cycle.
    start = 1'b1;
    a     = 4'd15;
    b     = 4'd1;
    wait_done(cyc, bok);
    check("b2b first latency", cyc, NORMAL_LAT);
    check("b2b first q", int'(q), 15);
    check("b2b first r", int'(r), 0);
    start = 1'b1;
    a     = 4'd5;
    b     = 4'd7;
    tick();
    check("b2b no gap busy", int'(busy), 1);
    check("b2b no gap done", int'(done), 0);
    start = 1'b0;
    wait_done(cyc, bok);
    check("b2b second latency", cyc, W);
    check("b2b second busy_run", int'(bok), 1);
    check("b2b second q", int'(q), 0);
    check("b2b second r", int'(r), 5);
    tick();

    // Start while busy is ignored.
    start = 1'b1;
    a     = 4'd9;
    b     = 4'd3;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    a     = 4'd1;
    b     = 4'd1;
    tick();
    start = 1'b0;
    cyc   = 3;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    check("ignore latency", cyc, NORMAL_LAT);
    check("ignore q", int'(q), 3);
    check("ignore r", int'(r), 0);
    tick();
    check("ignore idle busy", int'(busy), 0);

    // Reset in the second RUN cycle aborts with no done pulse.
    start = 1'b1;
    a     = 4'd12;
    b     = 4'd5;
    tick();
    start = 1'b0;
    tick();
    check("abort running", int'(busy), 1);
    rst_n  = 1'b0;
    n_done = 0;
    tick();
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort q", int'(q), 0);
    check("abort r", int'(r), 0);
    check("abort div_zero", int'(div_zero), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) n_done++;
    end
    check("abort no done pulse", n_done, 0);
    rst_n = 1'b1;
    run_op(4'd12, 4'd5, 4'd2, 4'd2, 0, NORMAL_LAT, "after_abort");

    // Exhaustive sweep against an arithmetic reference.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 1; ib < 16; ib++) begin
        run_op(W'(ia), W'(ib), W'(ia / ib), W'(ia % ib), 0, NORMAL_LAT, "sweep");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
